// File: rtl/m_ifetch.sv
// Instruction-fetch stage: owns the PC, loads IF/ID and turns resolved branches into BTB writes.
// Optional build macro M_IFETCH_BTB_INVAL_EN: a mispredicted not-taken branch also clears its BTB entry.
//
// state | meaning
// BOOT  | PC held at RESET_PC and IF/ID invalid; stall and redirects are ignored
// RUN   | normal fetch with redirect > stall > BTB prediction > PC+4
module m_ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        w_clock,
  input  logic        w_rst_n,
  input  logic        w_stall,
  output logic [31:0] w_pc,
  input  logic        w_btb_hit,
  input  logic [31:0] w_btb_dout,
  input  logic [31:0] w_imem_data,
  output logic        w_if_valid,
  output logic [31:0] w_if_pc,
  output logic [31:0] w_if_ir,
  output logic        w_if_pred,
  output logic [31:0] w_if_ptgt,
  input  logic        w_br_valid,
  input  logic [31:0] w_br_pc,
  input  logic        w_br_taken,
  input  logic [31:0] w_br_tgt,
  input  logic        w_br_mispred,
  output logic        w_btb_we,
  output logic [4:0]  w_btb_wa,
  output logic [57:0] w_btb_wd
);

  typedef enum logic {S_BOOT, S_RUN} state_t;

  state_t      state, state_nxt;
  logic        redirect;
  logic [31:0] pc_plus4;
  logic [31:0] pc_nxt;
  logic [31:0] ptgt_nxt;
  logic        if_load;
  logic        if_flush;
  logic        upd_we;
  logic [57:0] upd_wd;

  assign redirect = w_br_valid & w_br_mispred;
  assign pc_plus4 = w_pc + 32'd4;

  always_ff @(posedge w_clock) begin
    if (!w_rst_n) state <= S_BOOT;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = S_RUN;
    pc_nxt    = w_pc;
    ptgt_nxt  = w_btb_hit ? w_btb_dout : pc_plus4;
    if_load   = 1'b0;
    if_flush  = 1'b0;
    upd_we    = 1'b0;
    upd_wd    = {1'b1, w_br_pc[31:7], w_br_tgt};
    case (state)
      S_BOOT: state_nxt = S_RUN;
      S_RUN: begin
        // flush wins over stall so the wrong-path instruction never survives
        if (redirect) begin
          pc_nxt   = w_br_taken ? w_br_tgt : w_br_pc + 32'd4;
          if_flush = 1'b1;
        end else if (!w_stall) begin
          pc_nxt  = ptgt_nxt;
          if_load = 1'b1;
        end
      end
    endcase
    if (w_br_valid && w_br_taken) begin
      upd_we = 1'b1;
    end
`ifdef M_IFETCH_BTB_INVAL_EN
    else if (redirect) begin
      upd_we = 1'b1;
      upd_wd = {1'b0, w_br_pc[31:7], 32'h0};
    end
`endif
  end

  always_ff @(posedge w_clock) begin
    if (!w_rst_n) begin
      w_pc       <= RESET_PC;
      w_if_valid <= 1'b0;
      w_if_pc    <= 32'h0;
      w_if_ir    <= 32'h0;
      w_if_pred  <= 1'b0;
      w_if_ptgt  <= 32'h0;
      w_btb_we   <= 1'b0;
      w_btb_wa   <= 5'h0;
      w_btb_wd   <= 58'h0;
    end else begin
      w_pc <= pc_nxt;
      if (if_flush) begin
        w_if_valid <= 1'b0;
      end else if (if_load) begin
        w_if_valid <= 1'b1;
        w_if_pc    <= w_pc;
        w_if_ir    <= w_imem_data;
        w_if_pred  <= w_btb_hit;
        w_if_ptgt  <= ptgt_nxt;
      end
      w_btb_we <= upd_we;
      if (upd_we) begin
        w_btb_wa <= w_br_pc[6:2];
        w_btb_wd <= upd_wd;
      end
    end
  end

endmodule

// File: tb/tb_m_ifetch.sv
// Scoreboard bench for m_ifetch: directed fetch/redirect/BTB cases, then randomized traffic
// checked against a per-cycle reference model of the fetch rules.
module tb_m_ifetch;
  localparam logic [31:0] RESET_PC = 32'h100;

  logic        clk = 1'b0;
  logic        rst_n, stall, btb_hit, br_valid, br_taken, br_mispred;
  logic [31:0] btb_dout, imem_data, br_pc, br_tgt;
  logic [31:0] pc, if_pc, if_ir, if_ptgt;
  logic        if_valid, if_pred, btb_we;
  logic [4:0]  btb_wa;
  logic [57:0] btb_wd;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] pc;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_ir;
    logic        if_pred;
    logic [31:0] if_ptgt;
    logic        btb_we;
    logic [4:0]  btb_wa;
    logic [57:0] btb_wd;
    logic        full;
  } exp_t;

  exp_t q[$];
  exp_t mdl;
  logic mboot;

  m_ifetch #(.RESET_PC(RESET_PC)) dut (
    .w_clock(clk), .w_rst_n(rst_n), .w_stall(stall), .w_pc(pc),
    .w_btb_hit(btb_hit), .w_btb_dout(btb_dout), .w_imem_data(imem_data),
    .w_if_valid(if_valid), .w_if_pc(if_pc), .w_if_ir(if_ir),
    .w_if_pred(if_pred), .w_if_ptgt(if_ptgt),
    .w_br_valid(br_valid), .w_br_pc(br_pc), .w_br_taken(br_taken),
    .w_br_tgt(br_tgt), .w_br_mispred(br_mispred),
    .w_btb_we(btb_we), .w_btb_wa(btb_wa), .w_btb_wd(btb_wd)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reference model: state after the coming edge, from the current model state and inputs.
  task automatic tick();
    exp_t n;
    n = mdl;
    n.full = 1'b0;
    if (!rst_n) begin
      n = '{pc: RESET_PC, if_valid: 1'b0, if_pc: 32'h0, if_ir: 32'h0, if_pred: 1'b0,
            if_ptgt: 32'h0, btb_we: 1'b0, btb_wa: 5'h0, btb_wd: 58'h0, full: 1'b1};
      mboot = 1'b1;
    end else begin
      if (!mboot) begin
        if (br_valid && br_mispred) begin
          n.pc = br_taken ? br_tgt : br_pc + 32'd4;
          n.if_valid = 1'b0;
        end else if (!stall) begin
          n.pc       = btb_hit ? btb_dout : mdl.pc + 32'd4;
          n.if_valid = 1'b1;
          n.if_pc    = mdl.pc;
          n.if_ir    = imem_data;
          n.if_pred  = btb_hit;
          n.if_ptgt  = n.pc;
        end
      end
      mboot = 1'b0;
      n.btb_we = 1'b0;
      if (br_valid && br_taken) begin
        n.btb_we = 1'b1;
        n.btb_wa = br_pc[6:2];
        n.btb_wd = {1'b1, br_pc[31:7], br_tgt};
      end
`ifdef M_IFETCH_BTB_INVAL_EN
      else if (br_valid && br_mispred) begin
        n.btb_we = 1'b1;
        n.btb_wa = br_pc[6:2];
        n.btb_wd = {1'b0, br_pc[31:7], 32'h0};
      end
`endif
    end
    mdl = n;
    q.push_back(n);
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("pc", {32'h0, pc}, {32'h0, e.pc});
      chk("if_valid", {63'h0, if_valid}, {63'h0, e.if_valid});
      if (e.if_valid || e.full) begin
        chk("if_pc", {32'h0, if_pc}, {32'h0, e.if_pc});
        chk("if_ir", {32'h0, if_ir}, {32'h0, e.if_ir});
        chk("if_pred", {63'h0, if_pred}, {63'h0, e.if_pred});
        chk("if_ptgt", {32'h0, if_ptgt}, {32'h0, e.if_ptgt});
      end
      chk("btb_we", {63'h0, btb_we}, {63'h0, e.btb_we});
      if (e.btb_we || e.full) begin
        chk("btb_wa", {59'h0, btb_wa}, {59'h0, e.btb_wa});
        chk("btb_wd", {6'h0, btb_wd}, {6'h0, e.btb_wd});
      end
    end
  end

  task automatic clr();
    stall = 1'b0; btb_hit = 1'b0; btb_dout = 32'h0; imem_data = $urandom();
    br_valid = 1'b0; br_pc = 32'h0; br_taken = 1'b0; br_tgt = 32'h0; br_mispred = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    mdl = '{pc: 32'h0, if_valid: 1'b0, if_pc: 32'h0, if_ir: 32'h0, if_pred: 1'b0,
            if_ptgt: 32'h0, btb_we: 1'b0, btb_wa: 5'h0, btb_wd: 58'h0, full: 1'b0};
    mboot = 1'b1;
    clr();
    rst_n = 1'b0;
    tick();
    tick();
    chk("reset_pc", {32'h0, pc}, 64'h100);
    rst_n = 1'b1;
    imem_data = $urandom(); tick();
    chk("boot_pc", {32'h0, pc}, 64'h100);
    chk("boot_valid", {63'h0, if_valid}, 64'h0);
    imem_data = $urandom(); tick();
    chk("run_pc", {32'h0, pc}, 64'h104);
    chk("run_if_pc", {32'h0, if_pc}, 64'h100);
    imem_data = $urandom(); tick();
    chk("run_pc2", {32'h0, pc}, 64'h108);
    // BTB predicts taken at 0x108
    btb_hit = 1'b1; btb_dout = 32'h200; imem_data = $urandom(); tick();
    chk("pred_pc", {32'h0, pc}, 64'h200);
    chk("pred_ptgt", {32'h0, if_ptgt}, 64'h200);
    chk("pred_flag", {63'h0, if_pred}, 64'h1);
    // stall together with a not-taken mispredict: flush beats stall
    clr(); stall = 1'b1; br_valid = 1'b1; br_mispred = 1'b1; br_pc = 32'h200; tick();
    chk("flush_pc", {32'h0, pc}, 64'h204);
    chk("flush_valid", {63'h0, if_valid}, 64'h0);
    // taken branch update
    clr(); br_valid = 1'b1; br_taken = 1'b1; br_pc = 32'h84; br_tgt = 32'h40; tick();
    chk("upd_we", {63'h0, btb_we}, 64'h1);
    chk("upd_wa", {59'h0, btb_wa}, 64'h1);
    chk("upd_wd", {6'h0, btb_wd}, {6'h0, 1'b1, 25'h1, 32'h40});
    // three-cycle stall then resume
    clr(); stall = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("stall_pc", {32'h0, pc}, 64'h208);
    chk("stall_if_pc", {32'h0, if_pc}, 64'h204);
    chk("stall_btb_we", {63'h0, btb_we}, 64'h0);
    clr(); tick();
    chk("resume_pc", {32'h0, pc}, 64'h20c);
    // mispredicted not-taken at 0x88
    clr(); br_valid = 1'b1; br_mispred = 1'b1; br_pc = 32'h88; tick();
    chk("nt_pc", {32'h0, pc}, 64'h8c);
`ifdef M_IFETCH_BTB_INVAL_EN
    chk("inval_we", {63'h0, btb_we}, 64'h1);
    chk("inval_wa", {59'h0, btb_wa}, 64'h2);
    chk("inval_vbit", {63'h0, btb_wd[57]}, 64'h0);
`else
    chk("noinval_we", {63'h0, btb_we}, 64'h0);
`endif
    // PC wrap at the top of the address space
    clr(); br_valid = 1'b1; br_mispred = 1'b1; br_taken = 1'b1; br_tgt = 32'hFFFF_FFFC; tick();
    chk("wrap_tgt", {32'h0, pc}, 64'hFFFF_FFFC);
    clr(); tick();
    chk("wrap_pc", {32'h0, pc}, 64'h0);
    chk("wrap_ptgt", {32'h0, if_ptgt}, 64'h0);
    // reset cancels a pending BTB write and redirect
    clr(); rst_n = 1'b0; br_valid = 1'b1; br_taken = 1'b1; br_mispred = 1'b1;
    br_pc = 32'h84; br_tgt = 32'h40; tick();
    chk("rst_cancel_we", {63'h0, btb_we}, 64'h0);
    chk("rst_cancel_pc", {32'h0, pc}, 64'h100);
    rst_n = 1'b1;
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst_n      = ($urandom_range(0, 149) != 0);
      stall      = ($urandom_range(0, 3) == 0);
      btb_hit    = ($urandom_range(0, 2) == 0);
      r = $urandom(); btb_dout = r & ~32'h3;
      imem_data  = $urandom();
      br_valid   = ($urandom_range(0, 3) == 0);
      r = $urandom(); br_pc = r & ~32'h3;
      r = $urandom(); br_tgt = r & ~32'h3;
      br_taken   = $urandom_range(0, 1) == 1;
      br_mispred = $urandom_range(0, 2) == 0;
      tick();
    end
    clr();
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() != 0) chk("scoreboard_drain", 64'(q.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/m_ifetch.md
# m_ifetch

Instruction-fetch stage that owns the program counter and drives the branch target buffer (BTB) lookup. Each cycle it fetches from instruction memory and selects the next PC. Candidates are an execute-stage redirect, the BTB prediction, or PC+4. It loads the IF/ID pipeline register, and it turns resolved-branch reports from execute into registered BTB write requests.

## Interface
- RESET_PC, 32'h0, PC value loaded by reset.
- w_clock  in  1  clock; all state updates on the rising edge.
- w_rst_n  in  1  reset, synchronous, active-low.
- w_stall  in  1  downstream hazard; holds PC and IF/ID.
- w_pc  out  32  current fetch PC; indexes the BTB and instruction memory.
- w_btb_hit  in  1  BTB hit for w_pc (combinational).
- w_btb_dout  in  32  predicted target for w_pc.
- w_imem_data  in  32  instruction at w_pc (combinational read).
- w_if_valid  out  1  IF/ID entry valid.
- w_if_pc  out  32  PC of the IF/ID instruction.
- w_if_ir  out  32  IF/ID instruction.
- w_if_pred  out  1  IF/ID instruction was predicted taken.
- w_if_ptgt  out  32  predicted target; PC+4 when not predicted.
- w_br_valid  in  1  execute resolved a branch or jump this cycle.
- w_br_pc  in  32  PC of the resolved branch.
- w_br_taken  in  1  actual direction.
- w_br_tgt  in  32  actual taken target.
- w_br_mispred  in  1  prediction wrong; qualified by w_br_valid.
- w_btb_we  out  1  BTB write enable.
- w_btb_wa  out  5  BTB write index.
- w_btb_wd  out  58  BTB entry in {valid, tag[24:0], target[31:0]} layout.

## Operation
- State machine:
  - BOOT, entered on reset: w_pc = RESET_PC and w_if_valid = 0. Moves to RUN unconditionally on the next edge. Stall is ignored in BOOT.
  - RUN: normal fetch.
- Next-PC priority in RUN, highest first:
  - redirect (w_br_valid & w_br_mispred): w_br_taken ? w_br_tgt : w_br_pc + 4;
  - w_stall: hold;
  - w_btb_hit: w_btb_dout;
  - otherwise w_pc + 4.
- All PC arithmetic is 32-bit and wraps modulo 2^32; PC+4 at 32'hFFFFFFFC gives 32'h0.
- IF/ID load, when not stalled and no redirect:
  - w_if_valid = 1, w_if_pc = w_pc, w_if_ir = w_imem_data;
  - w_if_pred = w_btb_hit;
  - w_if_ptgt = w_btb_hit ? w_btb_dout : w_pc + 4.
- On redirect, w_if_valid is cleared on the next edge even if w_stall = 1 (flush beats stall). The other IF/ID fields may hold.
- On stall without redirect, all IF/ID fields hold.
- BTB update is registered. When w_br_valid & w_br_taken, the next edge sets:
  - w_btb_we = 1;
  - w_btb_wa = w_br_pc[6:2];
  - w_btb_wd = {1'b1, w_br_pc[31:7], w_br_tgt}.
  - Otherwise w_btb_we = 0; w_btb_wa and w_btb_wd are don't-care.
- Updates are issued independently of w_stall.

## Timing
- Reset values: w_pc = RESET_PC, w_if_valid = 0, w_if_pc = 0, w_if_ir = 0, w_if_pred = 0, w_if_ptgt = 0, w_btb_we = 0, w_btb_wa = 0, w_btb_wd = 0.
- Reset asserted mid-operation overrides redirect, stall and update in the same edge. It also cancels any pending BTB write.
- Fetch latency is one cycle from w_pc to the IF/ID outputs.
- Redirect penalty is one bubble: the target PC appears on w_pc the edge after w_br_mispred, with w_if_valid = 0.
- BTB write is visible on w_btb_we one cycle after w_br_valid. The new entry first affects w_btb_hit two cycles after resolution.

## Configuration
- M_IFETCH_BTB_INVAL_EN defined: a mispredicted not-taken resolution also writes the BTB. The trigger is w_br_valid & w_br_mispred & !w_br_taken, and the write is w_btb_wd = {1'b0, w_br_pc[31:7], 32'h0} at index w_br_pc[6:2]. This removes the stale entry.
- Undefined: not-taken resolutions never write the BTB, and stale entries persist until overwritten.

## Test plan
- Reset, then release:
  - w_pc = RESET_PC (use 32'h100) for two cycles with w_if_valid = 0 (BOOT).
  - Then w_pc = 104, 108 with w_if_valid = 1 and w_if_pc lagging by one cycle.
- BTB predicts taken: w_btb_hit = 1, w_btb_dout = 32'h200 at w_pc = 32'h108 -> next w_pc = 32'h200; w_if_pred = 1, w_if_ptgt = 32'h200.
- Stall plus redirect in the same cycle: w_stall = 1 with a mispredict whose w_br_taken = 0 and w_br_pc = 32'h200 -> next w_pc = 32'h204 and w_if_valid = 0.
- Taken branch update: w_br_valid = 1, w_br_taken = 1, w_br_pc = 32'h0000_0084, w_br_tgt = 32'h40 -> next cycle w_btb_we = 1, w_btb_wa = 1, w_btb_wd = {1, 25'h1, 32'h40}.
- Stall held for 3 cycles -> w_pc and all IF/ID outputs unchanged; fetch resumes at PC+4 after the stall drops.
- With M_IFETCH_BTB_INVAL_EN: a mispredicted not-taken branch at 32'h88 -> w_btb_we = 1, w_btb_wa = 2, valid bit 0. Without the macro -> w_btb_we stays 0.
